parity_share_ctrl: RTL and testbench

- Shares one bit-serial ones-count/parity engine among NUM_REQ requesters using round-robin arbitration.
- Per transaction: latch the granted requester's byte, shift it through a ones counter one bit per cycle, then report count, parity and requester id.
- Sits between producer blocks and the single parity resource. Trades latency for area versus a per-requester combinational parity tree.

---
 rtl/parity_pkg.sv | 28 ++
 rtl/parity_rr_pick.sv | 30 +++
 rtl/parity_share_ctrl.sv | 131 +++++++++++++
 tb/tb_parity_share_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// Shared types and helpers for the parity_share_ctrl slice.
// Optional early-exit scan is enabled with PARITY_EARLY_EXIT_EN (see parity_share_ctrl).
package parity_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SCAN = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_SCAN = ST_SCAN,
      S_DONE = ST_DONE
   } state_e;

   localparam int DEF_NUM_REQ = 4;
   localparam int DEF_DATA_W  = 8;

   // Ceiling log2, usable in parameter expressions.
   function automatic int clog2_f(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/parity_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
module parity_rr_pick
   import parity_pkg::*;
#(
   parameter  int NUM_REQ = DEF_NUM_REQ,
   localparam int ID_W    = clog2_f(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic               gnt_vld,
   output logic [ID_W-1:0]    gnt_id
);

   int idx;

   // Walk offsets from highest to lowest so the nearest request wins last.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_id  = '0;
      idx     = 0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         idx = (int'(ptr) + i) % NUM_REQ;
         if (req[idx]) begin
            gnt_vld = 1'b1;
            gnt_id  = ID_W'(idx);
         end
      end
   end

endmodule

// File: rtl/parity_share_ctrl.sv
// Shared bit-serial ones-count/parity engine with round-robin arbitration.
// Define PARITY_EARLY_EXIT_EN to end the scan once the remaining bits are all zero.
module parity_share_ctrl
   import parity_pkg::*;
#(
   parameter  int NUM_REQ = DEF_NUM_REQ,
   parameter  int DATA_W  = DEF_DATA_W,
   localparam int CNT_W   = clog2_f(DATA_W + 1),
   localparam int ID_W    = clog2_f(NUM_REQ)
) (
   input  logic                      Clk,
   input  logic                      Reset_n,
   input  logic [NUM_REQ-1:0]        Req,
   input  logic [NUM_REQ*DATA_W-1:0] Data,
   output logic [NUM_REQ-1:0]        Ack,
   output logic                      Busy,
   output logic                      Done,
   output logic [ID_W-1:0]           Done_id,
   output logic [CNT_W-1:0]          Ones_count,
   output logic                      Parity
);

   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   logic [NUM_REQ-1:0][DATA_W-1:0] words;
   assign words = Data;

   state_e               state_q, state_d;
   logic [ID_W-1:0]      ptr_q, ptr_d;
   logic [ID_W-1:0]      gid_q, gid_d;
   logic [DATA_W-1:0]    shreg_q, shreg_d;
   logic [CNT_W-1:0]     bitcnt_q, bitcnt_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [NUM_REQ-1:0]   ack_q, ack_d;
   logic                 done_q, done_d;
   logic [ID_W-1:0]      done_id_q, done_id_d;
   logic [CNT_W-1:0]     ones_q, ones_d;

   logic                 gnt_vld;
   logic [ID_W-1:0]      gnt_id;
   logic                 last;

   parity_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req     (Req),
      .ptr     (ptr_q),
      .gnt_vld (gnt_vld),
      .gnt_id  (gnt_id)
   );

`ifdef PARITY_EARLY_EXIT_EN
   assign last = (bitcnt_q == LAST_BIT) || (shreg_q[DATA_W-1:1] == '0);
`else
   assign last = (bitcnt_q == LAST_BIT);
`endif

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      gid_d     = gid_q;
      shreg_d   = shreg_q;
      bitcnt_d  = bitcnt_q;
      cnt_d     = cnt_q;
      ack_d     = '0;
      done_d    = 1'b0;
      done_id_d = done_id_q;
      ones_d    = ones_q;
      case (state_q)
         S_IDLE: begin
            if (gnt_vld) begin
               shreg_d        = words[gnt_id];
               cnt_d          = '0;
               bitcnt_d       = '0;
               gid_d          = gnt_id;
               ack_d[gnt_id]  = 1'b1;
               state_d        = S_SCAN;
            end
         end
         S_SCAN: begin
            cnt_d    = cnt_q + CNT_W'(shreg_q[0]);
            shreg_d  = shreg_q >> 1;
            bitcnt_d = bitcnt_q + CNT_W'(1);
            if (last) begin
               ones_d    = cnt_d;
               done_d    = 1'b1;
               done_id_d = gid_q;
               state_d   = S_DONE;
            end
         end
         S_DONE: begin
            // Pointer moves past the requester just served.
            ptr_d   = (gid_q == ID_W'(NUM_REQ - 1)) ? '0 : gid_q + ID_W'(1);
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state_q   <= S_IDLE;
         ptr_q     <= '0;
         gid_q     <= '0;
         shreg_q   <= '0;
         bitcnt_q  <= '0;
         cnt_q     <= '0;
         ack_q     <= '0;
         done_q    <= 1'b0;
         done_id_q <= '0;
         ones_q    <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         gid_q     <= gid_d;
         shreg_q   <= shreg_d;
         bitcnt_q  <= bitcnt_d;
         cnt_q     <= cnt_d;
         ack_q     <= ack_d;
         done_q    <= done_d;
         done_id_q <= done_id_d;
         ones_q    <= ones_d;
      end
   end

   assign Ack        = ack_q;
   assign Busy       = (state_q != S_IDLE);
   assign Done       = done_q;
   assign Done_id    = done_id_q;
   assign Ones_count = ones_q;
   assign Parity     = ones_q[0];

endmodule

// File: tb/tb_parity_share_ctrl.sv
// Scoreboard bench for parity_share_ctrl: transaction-level model predicts grants,
// results and Done timing; a negedge monitor compares against the DUT.
module tb_parity_share_ctrl;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int CW = 4;
   localparam int IW = 2;

   logic            Clk = 1'b0;
   logic            Reset_n = 1'b0;
   logic [N-1:0]    Req = '0;
   logic [N*W-1:0]  Data = '0;
   logic [N-1:0]    Ack;
   logic            Busy;
   logic            Done;
   logic [IW-1:0]   Done_id;
   logic [CW-1:0]   Ones_count;
   logic            Parity;

   always #5 Clk = ~Clk;

   parity_share_ctrl dut (
      .Clk        (Clk),
      .Reset_n    (Reset_n),
      .Req        (Req),
      .Data       (Data),
      .Ack        (Ack),
      .Busy       (Busy),
      .Done       (Done),
      .Done_id    (Done_id),
      .Ones_count (Ones_count),
      .Parity     (Parity)
   );

   typedef struct {
      int id;
      int ones;
      int par;
      int t;
   } exp_t;

   exp_t         q[$];
   exp_t         pend;
   int           pend_t = -1;
   int           cyc = 0;
   int           rem = 0;
   int           mptr = 0;
   logic [N-1:0] m_ack = '0;
   int           m_ones = 0, m_par = 0, m_id = 0;
   int           n_cmp = 0, n_bad = 0;
   bit           sticky = 0;
   bit           rand_mode = 0;
   logic [N-1:0] rearm = '0;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Number of scan edges from capture until the result is registered.
   function automatic int scan_len(input logic [W-1:0] w);
`ifdef PARITY_EARLY_EXIT_EN
      int h;
      h = -1;
      for (int i = 0; i < W; i++) if (w[i]) h = i;
      return (h < 0) ? 1 : h + 1;
`else
      return (w === w) ? W : W;
`endif
   endfunction

   // Reference model: one transaction at a time, round-robin from mptr.
   always @(posedge Clk) begin : model
      int           g;
      int           ones;
      int           k;
      logic [W-1:0] w;
      cyc = cyc + 1;
      m_ack = '0;
      if (!Reset_n) begin
         rem = 0; mptr = 0; q.delete(); pend_t = -1;
         m_ones = 0; m_par = 0; m_id = 0;
      end else begin
         if (pend_t == cyc) begin
            m_ones = pend.ones; m_par = pend.par; m_id = pend.id; pend_t = -1;
         end
         if (rem == 0) begin
            if (Req != '0) begin
               g = -1;
               for (int i = 0; i < N; i++)
                  if (g < 0 && Req[(mptr + i) % N]) g = (mptr + i) % N;
               w = Data[g*W +: W];
               ones = 0;
               for (int b = 0; b < W; b++) ones += int'(w[b]);
               k = scan_len(w);
               pend = '{g, ones, ones % 2, cyc + k};
               pend_t = pend.t;
               q.push_back(pend);
               m_ack[g] = 1'b1;
               mptr = (g + 1) % N;
               rem = k + 1;
            end
         end else begin
            rem = rem - 1;
         end
      end
   end

   always @(negedge Clk) begin : monitor
      exp_t e;
      chk("busy", int'(Busy), int'(rem > 0));
      chk("ack", int'(Ack), int'(m_ack));
      if (Done) begin
         if (q.size() == 0) begin
            chk("done_unexpected", int'(Done), 0);
         end else begin
            e = q.pop_front();
            chk("done_id", int'(Done_id), e.id);
            chk("ones_count", int'(Ones_count), e.ones);
            chk("parity", int'(Parity), e.par);
            chk("done_cycle", cyc, e.t);
         end
      end else if (q.size() > 0 && q[0].t <= cyc) begin
         chk("done_missing", int'(Done), 1);
         q.delete(0);
      end
      chk("hold_ones", int'(Ones_count), m_ones);
      chk("hold_par", int'(Parity), m_par);
      chk("hold_id", int'(Done_id), m_id);
   end

   task automatic raise(input int k, input logic [W-1:0] w);
      Data[k*W +: W] = w;
      Req[k] = 1'b1;
   endtask

   function automatic logic [W-1:0] rand_word();
      case ($urandom_range(0, 5))
         0:       return 8'h00;
         1:       return 8'h80;
         2:       return 8'hFF;
         default: return W'($urandom);
      endcase
   endfunction

   // One cycle of requester behaviour: drop on Ack, optional re-arm / random raise.
   task automatic step();
      logic [N-1:0] acked;
      @(negedge Clk);
      Req = Req | rearm;
      rearm = '0;
      acked = Ack;
      for (int k = 0; k < N; k++) begin
         if (acked[k]) begin
            Req[k] = 1'b0;
            if (sticky) rearm[k] = 1'b1;
         end else if (rand_mode && !Req[k] && $urandom_range(0, 3) == 0) begin
            raise(k, rand_word());
         end
      end
   endtask

   task automatic wait_idle(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (rem == 0 && Req == '0 && rearm == '0 && q.size() == 0) return;
         step();
      end
      n_cmp++;
      n_bad++;
      $display("FAIL idle_timeout: still busy after %0d cycles (rem %0d, queue %0d)",
               budget, rem, q.size());
   endtask

   initial begin
      Reset_n = 1'b0;
      repeat (3) step();
      Reset_n = 1'b1;
      step();
      raise(0, 8'hA5);
      wait_idle(40);

      // All four requesting, each re-requests after its Ack.
      step();
      raise(0, 8'h01); raise(1, 8'h03); raise(2, 8'h07); raise(3, 8'hFF);
      sticky = 1;
      repeat (42) step();
      sticky = 0;
      wait_idle(120);

      // Move pointer to 2, then simultaneous 0 and 1 exercise wrap.
      step();
      raise(1, 8'h3C);
      wait_idle(40);
      step();
      raise(0, 8'h00); raise(1, 8'h80);
      wait_idle(60);

      // Late request during another requester's scan.
      step();
      raise(0, 8'h5A);
      repeat (3) step();
      raise(1, 8'hC3);
      wait_idle(60);

      // Reset mid-scan, then compete 0 vs 2 to show the pointer cleared.
      step();
      raise(0, 8'hFF);
      repeat (4) step();
      Reset_n = 1'b0;
      repeat (2) step();
      Reset_n = 1'b1;
      raise(0, 8'h81); raise(2, 8'h0F);
      wait_idle(60);

      rand_mode = 1;
      repeat (600) step();
      rand_mode = 0;
      wait_idle(300);

      chk("leftover_expected", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
